// File: rtl/traffic_light_monitor.sv
// Receive-side checker for a red/yellow/green lamp interface: decodes the lamp phase,
// times each phase in seconds, flags illegal combinations/order/durations and counts cycles.
module traffic_light_monitor #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int RED_SEC       = 20,
  parameter int GREEN_SEC     = 20,
  parameter int YELLOW_SEC    = 20,
  parameter int TOL_SEC       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        red_in,
  input  logic        yellow_in,
  input  logic        green_in,
  input  logic        clear,
  output logic [1:0]  phase,
  output logic [5:0]  phase_sec,
  output logic [15:0] cycle_count,
  output logic [3:0]  err_flags,
  output logic        fault
);

  localparam int              PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]      TOL7      = 7'(TOL_SEC);

  typedef enum logic [2:0] {S_INIT, S_RED, S_GREEN, S_YELLOW, S_FAULT} state_t;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  function automatic logic [6:0] dur_of(input state_t s);
    case (s)
      S_RED:   return 7'(RED_SEC);
      S_GREEN: return 7'(GREEN_SEC);
      default: return 7'(YELLOW_SEC);
    endcase
  endfunction

  function automatic logic [6:0] lo_lim(input logic [6:0] d);
    return (d > TOL7) ? d - TOL7 : 7'd0;
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      S_RED:   return S_GREEN;
      S_GREEN: return S_YELLOW;
      default: return S_RED;
    endcase
  endfunction

  // Lamp vectors are packed as {red, green, yellow}
  logic [2:0]    sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, sec_inc;
  logic [15:0]   cnt_q, cnt_d;
  logic [3:0]    err_q, err_d, new_err;
  logic          first_q, first_d;
  logic [1:0]    phase_q, phase_d;
  logic          fault_q, fault_d;
  logic          multi, dark, wrap, exit_ok;
  state_t        lamp_st;
  logic [6:0]    dur, hi, lo;

  always_comb begin
    multi   = (sync2_q[2] & sync2_q[1]) | (sync2_q[2] & sync2_q[0]) | (sync2_q[1] & sync2_q[0]);
    dark    = (sync2_q == 3'b000);
    lamp_st = S_INIT;
    case (sync2_q)
      3'b100:  lamp_st = S_RED;
      3'b010:  lamp_st = S_GREEN;
      3'b001:  lamp_st = S_YELLOW;
      default: lamp_st = S_INIT;
    endcase

    wrap    = (presc_q == PRESC_MAX);
    sec_inc = wrap ? sat_inc6(sec_q) : sec_q;
    dur     = dur_of(state_q);
    hi      = dur + TOL7;
    lo      = lo_lim(dur);
    // A partial first phase after INIT is never judged on exit
    exit_ok = first_q || (({1'b0, sec_q} >= lo) && ({1'b0, sec_q} <= hi));

    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    new_err = 4'b0000;

    case (state_q)
      S_INIT: begin
        presc_d = '0;
        sec_d   = '0;
        if (multi) begin
          new_err[0] = 1'b1;
          state_d    = S_FAULT;
        end else if (!dark) begin
          state_d = lamp_st;
          first_d = 1'b1;
        end
      end
      S_RED, S_GREEN, S_YELLOW: begin
        if (multi) begin
          new_err[0] = 1'b1;
          state_d    = S_FAULT;
        end else if (dark) begin
          new_err[1] = 1'b1;
          state_d    = S_FAULT;
        end else if (lamp_st == state_q) begin
          presc_d = wrap ? '0 : presc_q + PW'(1);
          sec_d   = sec_inc;
          if ({1'b0, sec_inc} > hi) begin
            new_err[3] = 1'b1;
            state_d    = S_FAULT;
          end
        end else if (lamp_st != next_of(state_q)) begin
          new_err[2] = 1'b1;
          state_d    = S_FAULT;
        end else if (!exit_ok) begin
          new_err[3] = 1'b1;
          state_d    = S_FAULT;
        end else begin
          state_d = lamp_st;
          presc_d = '0;
          sec_d   = '0;
          first_d = 1'b0;
          if ((state_q == S_YELLOW) && !first_q) cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        presc_d = '0;
        sec_d   = '0;
        if (clear) state_d = S_INIT;
      end
    endcase

    if (state_d == S_FAULT) begin
      presc_d = '0;
      sec_d   = '0;
    end

    // A newly detected error wins over a simultaneous clear
    err_d = (clear ? 4'b0000 : err_q) | new_err;

    case (state_d)
      S_RED:    phase_d = 2'd1;
      S_GREEN:  phase_d = 2'd2;
      S_YELLOW: phase_d = 2'd3;
      default:  phase_d = 2'd0;
    endcase
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      state_q <= S_INIT;
      presc_q <= '0;
      sec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= 1'b0;
      phase_q <= '0;
      fault_q <= 1'b0;
    end else begin
      sync1_q <= {red_in, green_in, yellow_in};
      sync2_q <= sync1_q;
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      phase_q <= phase_d;
      fault_q <= fault_d;
    end
  end

  assign phase       = phase_q;
  assign phase_sec   = sec_q;
  assign cycle_count = cnt_q;
  assign err_flags   = err_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scenario bench for traffic_light_monitor: 4 ticks/s, 3 s nominal phases, 1 s tolerance.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        red_in, yellow_in, green_in, clear;
  logic [1:0]  phase;
  logic [5:0]  phase_sec;
  logic [15:0] cycle_count;
  logic [3:0]  err_flags;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Lamp patterns as {red, yellow, green}
  localparam logic [2:0] L_D = 3'b000, L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001, L_RG = 3'b101;

  typedef struct {
    string       name;
    logic [2:0]  rgy;
    logic        clr;
    int          n;
    logic [28:0] exp;
  } row_t;

  typedef struct {
    string       name;
    logic [28:0] exp;
  } exp_t;

  exp_t sb[$];

  traffic_light_monitor #(
    .TICKS_PER_SEC(4), .RED_SEC(3), .GREEN_SEC(3), .YELLOW_SEC(3), .TOL_SEC(1)
  ) dut (
    .clk(clk), .reset(reset), .red_in(red_in), .yellow_in(yellow_in), .green_in(green_in),
    .clear(clear), .phase(phase), .phase_sec(phase_sec), .cycle_count(cycle_count),
    .err_flags(err_flags), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [28:0] snap(int ph, int sec, int cyc, logic [3:0] err, logic flt);
    return {2'(ph), 6'(sec), 16'(cyc), err, flt};
  endfunction

  function automatic row_t mk(string nm, logic [2:0] rgy, logic clr, int n,
                              int ph, int sec, int cyc, logic [3:0] err, logic flt);
    row_t r;
    r.name = nm; r.rgy = rgy; r.clr = clr; r.n = n;
    r.exp  = snap(ph, sec, cyc, err, flt);
    return r;
  endfunction

  function automatic logic [28:0] obs();
    return {phase, phase_sec, cycle_count, err_flags, fault};
  endfunction

  function automatic string fmt(logic [28:0] v);
    return $sformatf("ph=%0d sec=%0d cyc=%0d err=%b flt=%b", v[28:27], v[26:21], v[20:5], v[4:1], v[0]);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; clear = 1'b0;
    {red_in, yellow_in, green_in} = L_R;
    e.name = "reset_hold"; e.exp = snap(0, 0, 0, 4'b0000, 1'b0);
    sb.push_back(e);
    step(3);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
    end
    {red_in, yellow_in, green_in} = L_D;
    reset = 1'b0;
    e.name = "reset_init_dark"; e.exp = snap(0, 0, 0, 4'b0000, 1'b0);
    sb.push_back(e);
    step(4);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
    end
  endtask

  task automatic test_nominal();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("nom_red1",    L_R, 1'b0, 12, 1, 2, 0, 4'b0000, 1'b0));
    rows.push_back(mk("nom_green1",  L_G, 1'b0, 12, 2, 2, 0, 4'b0000, 1'b0));
    rows.push_back(mk("nom_yellow1", L_Y, 1'b0, 12, 3, 2, 0, 4'b0000, 1'b0));
    rows.push_back(mk("nom_red2",    L_R, 1'b0, 12, 1, 2, 1, 4'b0000, 1'b0));
    rows.push_back(mk("nom_green2",  L_G, 1'b0, 12, 2, 2, 1, 4'b0000, 1'b0));
    rows.push_back(mk("nom_yellow2", L_Y, 1'b0, 12, 3, 2, 1, 4'b0000, 1'b0));
    rows.push_back(mk("nom_red3",    L_R, 1'b0, 12, 1, 2, 2, 4'b0000, 1'b0));
    foreach (rows[i]) begin
      {red_in, yellow_in, green_in} = rows[i].rgy;
      clear = rows[i].clr;
      e.name = rows[i].name; e.exp = rows[i].exp;
      sb.push_back(e);
      step(rows[i].n);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
      end
    end
  endtask

  task automatic test_overstay();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("over_green_at4", L_G, 1'b0, 22, 2, 4, 2, 4'b0000, 1'b0));
    rows.push_back(mk("over_fault",     L_G, 1'b0, 1,  0, 0, 2, 4'b1000, 1'b1));
    foreach (rows[i]) begin
      {red_in, yellow_in, green_in} = rows[i].rgy;
      clear = rows[i].clr;
      e.name = rows[i].name; e.exp = rows[i].exp;
      sb.push_back(e);
      step(rows[i].n);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
      end
    end
  endtask

  task automatic test_clear();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("clr_fault_ignores", L_D, 1'b0, 3, 0, 0, 2, 4'b1000, 1'b1));
    rows.push_back(mk("clr_to_init",       L_D, 1'b1, 1, 0, 0, 2, 4'b0000, 1'b0));
    rows.push_back(mk("clr_init_dark",     L_D, 1'b0, 2, 0, 0, 2, 4'b0000, 1'b0));
    foreach (rows[i]) begin
      {red_in, yellow_in, green_in} = rows[i].rgy;
      clear = rows[i].clr;
      e.name = rows[i].name; e.exp = rows[i].exp;
      sb.push_back(e);
      step(rows[i].n);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
      end
    end
  endtask

  task automatic test_short_and_order();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("short_red",       L_R, 1'b0, 12, 1, 2, 2, 4'b0000, 1'b0));
    rows.push_back(mk("short_green",     L_G, 1'b0, 4,  2, 0, 2, 4'b0000, 1'b0));
    rows.push_back(mk("short_pre_exit",  L_Y, 1'b0, 2,  2, 0, 2, 4'b0000, 1'b0));
    rows.push_back(mk("short_dur_err",   L_Y, 1'b0, 1,  0, 0, 2, 4'b1000, 1'b1));
    rows.push_back(mk("order_fault",     L_D, 1'b0, 3,  0, 0, 2, 4'b1000, 1'b1));
    rows.push_back(mk("order_clear",     L_D, 1'b1, 1,  0, 0, 2, 4'b0000, 1'b0));
    rows.push_back(mk("order_red",       L_R, 1'b0, 12, 1, 2, 2, 4'b0000, 1'b0));
    rows.push_back(mk("order_r_to_y",    L_Y, 1'b0, 3,  0, 0, 2, 4'b0100, 1'b1));
    foreach (rows[i]) begin
      {red_in, yellow_in, green_in} = rows[i].rgy;
      clear = rows[i].clr;
      e.name = rows[i].name; e.exp = rows[i].exp;
      sb.push_back(e);
      step(rows[i].n);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
      end
    end
  endtask

  task automatic test_lamp_faults();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("lamp_fault_hold",  L_D,  1'b0, 3,  0, 0, 2, 4'b0100, 1'b1));
    rows.push_back(mk("lamp_clear1",      L_D,  1'b1, 1,  0, 0, 2, 4'b0000, 1'b0));
    rows.push_back(mk("lamp_red1",        L_R,  1'b0, 12, 1, 2, 2, 4'b0000, 1'b0));
    rows.push_back(mk("multi_pin_cyc",    L_RG, 1'b0, 1,  1, 2, 2, 4'b0000, 1'b0));
    rows.push_back(mk("multi_in_sync",    L_R,  1'b0, 1,  1, 2, 2, 4'b0000, 1'b0));
    rows.push_back(mk("multi_err",        L_R,  1'b0, 1,  0, 0, 2, 4'b0001, 1'b1));
    rows.push_back(mk("dark_prep_fault",  L_D,  1'b0, 3,  0, 0, 2, 4'b0001, 1'b1));
    rows.push_back(mk("lamp_clear2",      L_D,  1'b1, 1,  0, 0, 2, 4'b0000, 1'b0));
    rows.push_back(mk("lamp_red2",        L_R,  1'b0, 12, 1, 2, 2, 4'b0000, 1'b0));
    rows.push_back(mk("dark_in_sync",     L_D,  1'b0, 2,  1, 2, 2, 4'b0000, 1'b0));
    rows.push_back(mk("dark_err",         L_D,  1'b0, 1,  0, 0, 2, 4'b0010, 1'b1));
    foreach (rows[i]) begin
      {red_in, yellow_in, green_in} = rows[i].rgy;
      clear = rows[i].clr;
      e.name = rows[i].name; e.exp = rows[i].exp;
      sb.push_back(e);
      step(rows[i].n);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
      end
    end
  endtask

  task automatic test_clear_race();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("race_fault_hold", L_D,  1'b0, 3, 0, 0, 2, 4'b0010, 1'b1));
    rows.push_back(mk("race_clear",      L_D,  1'b1, 1, 0, 0, 2, 4'b0000, 1'b0));
    rows.push_back(mk("race_multi_sync", L_RG, 1'b0, 2, 0, 0, 2, 4'b0000, 1'b0));
    rows.push_back(mk("race_set_wins",   L_RG, 1'b1, 1, 0, 0, 2, 4'b0001, 1'b1));
    foreach (rows[i]) begin
      {red_in, yellow_in, green_in} = rows[i].rgy;
      clear = rows[i].clr;
      e.name = rows[i].name; e.exp = rows[i].exp;
      sb.push_back(e);
      step(rows[i].n);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
      end
    end
  endtask

  task automatic test_mid_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("mid_fault_hold", L_D, 1'b0, 3, 0, 0, 2, 4'b0001, 1'b1));
    rows.push_back(mk("mid_clear",      L_D, 1'b1, 1, 0, 0, 2, 4'b0000, 1'b0));
    for (int k = 0; k < 4; k++) begin
      rows.push_back(mk($sformatf("mid_red%0d", k),    L_R, 1'b0, 12, 1, 2, 2 + k, 4'b0000, 1'b0));
      rows.push_back(mk($sformatf("mid_green%0d", k),  L_G, 1'b0, 12, 2, 2, 2 + k, 4'b0000, 1'b0));
      rows.push_back(mk($sformatf("mid_yellow%0d", k), L_Y, 1'b0, 12, 3, 2, 2 + k, 4'b0000, 1'b0));
    end
    foreach (rows[i]) begin
      {red_in, yellow_in, green_in} = rows[i].rgy;
      clear = rows[i].clr;
      e.name = rows[i].name; e.exp = rows[i].exp;
      sb.push_back(e);
      step(rows[i].n);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
      end
    end
    // Reset lands between clock edges; outputs must drop without waiting for clk
    #3;
    reset = 1'b1;
    e.name = "async_reset_zero"; e.exp = snap(0, 0, 0, 4'b0000, 1'b0);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
    end
    {red_in, yellow_in, green_in} = L_R;
    step(2);
    reset = 1'b0;
    e.name = "post_reset_red"; e.exp = snap(1, 0, 0, 4'b0000, 1'b0);
    sb.push_back(e);
    step(3);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
    end
    {red_in, yellow_in, green_in} = L_G;
    e.name = "first_phase_unchecked"; e.exp = snap(2, 0, 0, 4'b0000, 1'b0);
    sb.push_back(e);
    step(3);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got %s required %s", e.name, fmt(obs()), fmt(e.exp));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overstay();
    test_clear();
    test_short_and_order();
    test_lamp_faults();
    test_clear_race();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
